// File: rtl/sccpu_dmem_resp_if.sv
// Request/response bus between the sccpu load/store path and the data-memory responder.
interface sccpu_dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sccpu_dmem_resp.sv
// Data-memory responder: one word access at a time with WAIT_CYC wait states.
// Optional DMEM_STATS_EN adds saturating load/store commit counters (rd_cnt, wr_cnt).
module sccpu_dmem_resp #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic               clock,
    input  logic               reset,
    sccpu_dmem_resp_if.slave   bus
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]        rd_cnt,
    output logic [15:0]        wr_cnt
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;

    logic                accept;
    logic                commit;
    logic                c_we;
    logic [31:0]         c_addr;
    logic [31:0]         c_wdata;
    logic                c_err;
    logic [ADDR_W-1:0]   c_idx;

    logic [31:0]         mem [DEPTH];

    // Commit operand comes straight from the bus when WAIT_CYC=0 commits at accept.
    assign c_err = (c_addr[1:0] != 2'b00) || ((c_addr >> (ADDR_W + 2)) != 32'd0);
    assign c_idx = c_addr[ADDR_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        case (state_q)
            ST_IDLE: begin
                c_we    = bus.req_we;
                c_addr  = bus.req_addr;
                c_wdata = bus.req_wdata;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYC - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus.req_ready <= (state_d == ST_IDLE);
            bus.rsp_valid <= (state_d == ST_RESP);
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (commit) begin
                bus.rsp_err   <= c_err;
                bus.rsp_rdata <= (c_err || c_we) ? 32'd0 : mem[c_idx];
            end else if ((state_q == ST_RESP) && bus.rsp_ready) begin
                bus.rsp_err   <= 1'b0;
                bus.rsp_rdata <= '0;
            end
        end
    end

    // Storage is deliberately not reset; erroneous stores never write.
    always_ff @(posedge clock) begin
        if (commit && c_we && !c_err) begin
            mem[c_idx] <= c_wdata;
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (commit && !c_err) begin
            if (c_we) begin
                if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end else begin
                if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
